nanocalc_seq: RTL
=================

# nanocalc_seq

Accumulator sequencer for the nanocalc 4-bit ALU. Queues commands from a valid/ready command port in a small FIFO, runs each one through the ALU with the accumulator as operand A, and writes the result back to the accumulator. Each completed command is reported on a valid/ready result port. It turns the single-shot combinational ALU into a chained multi-step calculator for the tile.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `clr` in 1: synchronous clear; flushes the FIFO, accumulator and flags.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept; `!full && !clr`, independent of `cmd_valid`.
- `cmd_load` in 1: 1 = load `cmd_data` into the accumulator; 0 = ALU op.
- `cmd_op` in 3: ALU operation code (encoding below).
- `cmd_data` in 4: operand B, or the load value.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_acc` out 4: accumulator after the command.
- `res_carry` out 1: carry/borrow flag after the command.
- `res_zero` out 1: zero flag after the command.
- `busy` out 1: `state != IDLE || fifo not empty`.

## Operation
- Handshake: a transfer happens on an edge where valid && ready. A push is a 8-bit instruction `{load, op, data}`.
- FSM states:
  - IDLE: if the FIFO is not empty, pop into the instruction register and go to EXEC.
  - EXEC: compute; on the edge, register acc/carry/zero and go to RESP.
  - RESP: hold `res_valid=1`. On `res_ready`, pop and go to EXEC if the FIFO is not empty, else go to IDLE.
- ALU (A=acc, B=data; carry is bit 4 of the 5-bit result unless stated):
  - 000 add A+B.
  - 001 sub A−B; carry=borrow.
  - 010 and.
  - 011 or.
  - 100 xor; carry=0 for 010–100.
  - 101 ~A; carry=0.
  - 110 A<<1; carry=A[3].
  - 111 eq; result=0001 and carry=1 if A==B, else 0000 and carry=0.
- Zero flag = (new acc == 0) for every command.
- Load: acc=data, carry=0, zero=(data==0).
- Result outputs are stable while `res_valid && !res_ready`. `res_*` mirror the live acc/flags registers.
- Full FIFO: `cmd_ready=0`; no push-when-full bypass, even with a simultaneous pop.
- Empty FIFO in IDLE: no bypass; a pushed command waits one edge.
- `clr` has priority over everything. Next cycle: FIFO empty, state IDLE, `res_valid=0`, acc=0, carry=0, zero=1. A push in the same cycle is dropped (`cmd_ready` is low).
- Reset values (also `rst_n` asserted mid-operation):
  - acc=0, carry=0, zero=1.
  - state IDLE, FIFO empty.
  - `res_valid=0`, `busy=0`, `cmd_ready=1`.

## Timing
- Command accepted at edge k into an idle, empty block: popped at k+1, result registered at k+2, so `res_valid=1` after edge k+2.
- Throughput: one result per 2 cycles with `res_ready` held high.
- FIFO pointers wrap modulo DEPTH. Count width is log2(DEPTH)+1.
- All outputs are registered except `cmd_ready` and `busy`, which are decoded from registers plus `clr`.

## Configuration
- `NANOCALC_ADC_EN` defined:
  - op 000 computes A+B+carry_flag.
  - op 001 computes A−B−carry_flag.
  - This enables multi-nibble chaining.
- `NANOCALC_ADC_EN` undefined: carry-in is tied to 0; all other behaviour is identical.

## Structure
- `nanocalc_pkg` holds:
  - op localparams OP_ADD..OP_EQ;
  - the FSM state enum (IDLE/EXEC/RESP);
  - the packed instruction struct `{load, op[2:0], data[3:0]}`.
- Sub-module `nanocalc_alu_core`: combinational; inputs a, b, op, cin; outputs result, carry, zero. The FIFO is inline.

## Test plan
- **Reset:** `rst_n` low with idle inputs → acc=0, zero=1, carry=0, `res_valid=0`, `busy=0`, `cmd_ready=1`.
- **Add chain:** load 9, add 8, add 0 → results:
  - 9/c0/z0;
  - 1/c1/z0;
  - then 1/c0 without `NANOCALC_ADC_EN`, or 2/c0 with it.
- **Subtract with borrow:** load 3, sub 5 → acc=E, carry=1, zero=0. Follow with load 7, eq 7 → acc=1, carry=1; then shl → acc=2, carry=0.
- **Backpressure:** `res_ready=0`, push 6 commands with DEPTH=4 → 1 in RESP, 4 queued, 6th sees `cmd_ready=0`. Release `res_ready` → 5 results in order, 2 cycles apart.
- **Latency:** single add accepted at edge k on an idle block → `res_valid` first high after edge k+2.
- **Clear mid-stream:** `clr` pulse in RESP with 3 queued → next cycle `res_valid=0`, `busy=0`, acc=0, zero=1; a new load of 4 then completes normally.

Source files
------------

// File: rtl/nanocalc_pkg.sv
// Shared types for the nanocalc accumulator sequencer: ALU op codes,
// sequencer FSM states and the packed command word held in the FIFO.
package nanocalc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic       load;
        logic [2:0] op;
        logic [3:0] data;
    } instr_t;

endpackage

// File: rtl/nanocalc_alu_core.sv
// Combinational 4-bit ALU. Operand A is the accumulator, B the command data.
// For subtraction the carry output is the borrow out of bit 3.
module nanocalc_alu_core
    import nanocalc_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [2:0] op,
    input  logic       cin,
    output logic [3:0] result,
    output logic       carry,
    output logic       zero
);

    logic [4:0] wide;

    // Op decode; carry is bit 4 of the widened result except where overridden.
    always_comb begin
        wide = 5'b0;
        case (op)
            OP_ADD: wide = {1'b0, a} + {1'b0, b} + {4'b0, cin};
            OP_SUB: wide = {1'b0, a} - {1'b0, b} - {4'b0, cin};
            OP_AND: wide = {1'b0, a & b};
            OP_OR:  wide = {1'b0, a | b};
            OP_XOR: wide = {1'b0, a ^ b};
            OP_NOT: wide = {1'b0, ~a};
            OP_SHL: wide = {a, 1'b0};
            OP_EQ:  wide = (a == b) ? 5'b1_0001 : 5'b0_0000;
            default: wide = 5'b0;
        endcase
        result = wide[3:0];
        carry  = wide[4];
        zero   = (wide[3:0] == 4'b0);
    end

endmodule

// File: rtl/nanocalc_seq.sv
// Accumulator sequencer: a small command FIFO feeds the ALU, each result is
// written back to the accumulator and presented on the result port.
// Build option: define NANOCALC_ADC_EN to feed the carry flag into add/sub
// (add-with-carry / subtract-with-borrow for multi-nibble chaining).
//
// state | meaning
// IDLE  | nothing in flight; pops the FIFO when it is non-empty
// EXEC  | instruction register valid; acc/flags update on this edge
// RESP  | result held on res_*; next pop happens on the res_ready edge
module nanocalc_seq
    import nanocalc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_acc,
    output logic       res_carry,
    output logic       res_zero,
    output logic       busy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    instr_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic            full, empty, push, pop;

    state_t          state_q, state_d;
    instr_t          instr_q;
    logic [3:0]      acc_q;
    logic            carry_q, zero_q, res_valid_q;

    logic [3:0]      alu_result;
    logic            alu_carry, alu_zero, alu_cin;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full && !clr;
    assign push      = cmd_valid && cmd_ready;

`ifdef NANOCALC_ADC_EN
    assign alu_cin = carry_q;
`else
    assign alu_cin = 1'b0;
`endif

    nanocalc_alu_core u_alu (
        .a      (acc_q),
        .b      (instr_q.data),
        .op     (instr_q.op),
        .cin    (alu_cin),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    // Next-state and FIFO pop decode.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = RESP;
            RESP: begin
                if (res_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, instruction register and registered res_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            res_valid_q <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_valid_q <= (state_d == RESP);
            if (pop) instr_q <= mem[rd_ptr];
        end
    end

    // FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{load: cmd_load, op: cmd_op, data: cmd_data};
    end

    // FIFO pointers and occupancy; clr flushes everything queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Accumulator and flags written back in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= 4'h0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else if (clr) begin
            acc_q   <= 4'h0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else if (state_q == EXEC) begin
            if (instr_q.load) begin
                acc_q   <= instr_q.data;
                carry_q <= 1'b0;
                zero_q  <= (instr_q.data == 4'h0);
            end else begin
                acc_q   <= alu_result;
                carry_q <= alu_carry;
                zero_q  <= alu_zero;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_acc   = acc_q;
    assign res_carry = carry_q;
    assign res_zero  = zero_q;
    assign busy      = (state_q != IDLE) || !empty;

endmodule
